// File: rtl/sliding_pattern_2d.sv
// rtl/sliding_pattern_2d.sv - tiles a PAT_H x PAT_W binary pattern over a frame, sliding the offset per frame
`timescale 1ns/1ps
module sliding_pattern_2d #(
    parameter int IMG_W  = 35,
    parameter int IMG_H  = 35,
    parameter int PAT_W  = 32,
    parameter int PAT_H  = 4,
    parameter int STEP_W = $clog2((PAT_W > PAT_H) ? PAT_W : PAT_H)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_en,
    input  logic [PAT_W*PAT_H-1:0]   pattern,
    input  logic                     load_pattern,
    input  logic [1:0]               dir,
    input  logic [STEP_W-1:0]        step,
    input  logic                     mask_ready,
    output logic                     mask_bit,
    output logic                     mask_valid,
    output logic                     frame_start,
    output logic                     line_end,
    output logic                     frame_end
);
    localparam int PN = PAT_W * PAT_H;
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CW = $clog2(PAT_W);
    localparam int RW = (PAT_H > 1) ? $clog2(PAT_H) : 1;
    localparam int IW = $clog2(PN);

    localparam logic [XW-1:0]     X_LAST  = XW'(IMG_W - 1);
    localparam logic [YW-1:0]     Y_LAST  = YW'(IMG_H - 1);
    localparam logic [CW-1:0]     C_LAST  = CW'(PAT_W - 1);
    localparam logic [RW-1:0]     R_LAST  = RW'(PAT_H - 1);
    localparam logic [STEP_W-1:0] SH_MAX  = STEP_W'(PAT_W - 1);
    localparam logic [STEP_W-1:0] SV_MAX  = STEP_W'(PAT_H - 1);
    localparam logic [CW:0]       PW_X    = (CW+1)'(PAT_W);
    localparam logic [RW:0]       PH_X    = (RW+1)'(PAT_H);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t          state;
    logic [PN-1:0]   pat_q;
    logic [PN-1:0]   shadow_q;
    logic            pending_q;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    logic [CW-1:0]   cx_q;
    logic [RW-1:0]   ry_q;
    logic [CW-1:0]   hoff_q;
    logic [RW-1:0]   voff_q;

    logic [CW-1:0]   s_h;
    logic [RW-1:0]   s_v;
    logic [CW:0]     h_sum;
    logic [RW:0]     v_sum;
    logic [CW-1:0]   h_inc, h_dec, hoff_next;
    logic [RW-1:0]   v_inc, v_dec, voff_next;
    logic [CW-1:0]   cx_inc;
    logic [RW-1:0]   ry_inc;
    logic [IW-1:0]   bit_idx;

    // Step is clamped to dimension-1 so a single conditional add/subtract completes the modulo.
    always_comb begin
        s_h   = (step > SH_MAX) ? CW'(PAT_W - 1) : CW'(step);
        s_v   = (step > SV_MAX) ? RW'(PAT_H - 1) : RW'(step);
        h_sum = {1'b0, hoff_q} + {1'b0, s_h};
        v_sum = {1'b0, voff_q} + {1'b0, s_v};
        h_inc = (h_sum >= PW_X) ? CW'(h_sum - PW_X) : CW'(h_sum);
        v_inc = (v_sum >= PH_X) ? RW'(v_sum - PH_X) : RW'(v_sum);
        h_dec = (hoff_q >= s_h) ? (hoff_q - s_h) : CW'(PW_X + {1'b0, hoff_q} - {1'b0, s_h});
        v_dec = (voff_q >= s_v) ? (voff_q - s_v) : RW'(PH_X + {1'b0, voff_q} - {1'b0, s_v});
        hoff_next = hoff_q;
        voff_next = voff_q;
        case (dir)
            2'b00:   hoff_next = h_inc;
            2'b01:   hoff_next = h_dec;
            2'b10:   voff_next = v_inc;
            default: voff_next = v_dec;
        endcase
        cx_inc  = (cx_q == C_LAST) ? '0 : cx_q + CW'(1);
        ry_inc  = (ry_q == R_LAST) ? '0 : ry_q + RW'(1);
        bit_idx = IW'(ry_q) * IW'(PAT_W) + IW'(cx_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pat_q     <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            cx_q      <= '0;
            ry_q      <= '0;
            hoff_q    <= '0;
            voff_q    <= '0;
        end else if (clk_en) begin
            if (state == IDLE) begin
                if (load_pattern) begin
                    pat_q  <= pattern;
                    x_q    <= '0;
                    y_q    <= '0;
                    cx_q   <= '0;
                    ry_q   <= '0;
                    hoff_q <= '0;
                    voff_q <= '0;
                    state  <= STREAM;
                end
            end else begin
                if (mask_ready) begin
                    if (x_q == X_LAST) begin
                        x_q <= '0;
                        if (y_q == Y_LAST) begin
                            y_q <= '0;
                            if (pending_q) begin
                                pat_q     <= shadow_q;
                                hoff_q    <= '0;
                                voff_q    <= '0;
                                cx_q      <= '0;
                                ry_q      <= '0;
                                pending_q <= 1'b0;
                            end else begin
                                hoff_q <= hoff_next;
                                voff_q <= voff_next;
                                cx_q   <= hoff_next;
                                ry_q   <= voff_next;
                            end
                        end else begin
                            y_q  <= y_q + YW'(1);
                            ry_q <= ry_inc;
                            cx_q <= hoff_q;
                        end
                    end else begin
                        x_q  <= x_q + XW'(1);
                        cx_q <= cx_inc;
                    end
                end
                // A load landing on the frame-end transfer is held for the following boundary.
                if (load_pattern) begin
                    shadow_q  <= pattern;
                    pending_q <= 1'b1;
                end
            end
        end
    end

    assign mask_valid  = (state == STREAM);
    assign mask_bit    = mask_valid & pat_q[bit_idx];
    assign line_end    = mask_valid & (x_q == X_LAST);
    assign frame_start = mask_valid & (x_q == '0) & (y_q == '0);
    assign frame_end   = line_end & (y_q == Y_LAST);

endmodule

// File: tb/tb_sliding_pattern_2d.sv
// tb/tb_sliding_pattern_2d.sv - self-checking bench for sliding_pattern_2d against a modulo-arithmetic model
`timescale 1ns/1ps
module tb_sliding_pattern_2d;
    localparam int IW = 35;
    localparam int IH = 35;
    localparam int PW = 8;
    localparam int PH = 2;
    localparam int SW = 3;
    localparam int FR = IW * IH;
    localparam int PN = PW * PH;
    localparam logic [PN-1:0] TEST_PAT = 16'hE007;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clk_en = 1'b1;
    logic          load_pattern = 1'b0;
    logic          mask_ready = 1'b0;
    logic [PN-1:0] pattern = '0;
    logic [1:0]    dir = 2'b00;
    logic [SW-1:0] step = '0;
    logic          mask_bit, mask_valid, frame_start, line_end, frame_end;

    sliding_pattern_2d #(.IMG_W(IW), .IMG_H(IH), .PAT_W(PW), .PAT_H(PH), .STEP_W(SW)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .pattern(pattern),
        .load_pattern(load_pattern), .dir(dir), .step(step), .mask_ready(mask_ready),
        .mask_bit(mask_bit), .mask_valid(mask_valid), .frame_start(frame_start),
        .line_end(line_end), .frame_end(frame_end)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    bit            m_stream = 0;
    bit            m_pending = 0;
    logic [PN-1:0] m_pat = '0;
    logic [PN-1:0] m_shadow = '0;
    int            m_hoff = 0, m_voff = 0, m_k = 0, n_frames = 0;
    logic [7:0]    cap0 = '0, cap1 = '0;
    int            ones_cnt = 0, last_ones = 0, fe_at = -1;
    logic [4:0]    snap;

    typedef struct {
        logic [1:0]    dir;
        logic [SW-1:0] step;
        logic [7:0]    exp0;
        logic [7:0]    exp1;
    } vec_t;
    vec_t tv[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        return (v > hi) ? hi : v;
    endfunction

    task automatic model_frame_end();
        if (m_pending) begin
            m_pat = m_shadow; m_hoff = 0; m_voff = 0; m_pending = 0;
        end else begin
            case (dir)
                2'b00:   m_hoff = (m_hoff + clampi(int'(step), PW-1)) % PW;
                2'b01:   m_hoff = (m_hoff - clampi(int'(step), PW-1) + PW) % PW;
                2'b10:   m_voff = (m_voff + clampi(int'(step), PH-1)) % PH;
                default: m_voff = (m_voff - clampi(int'(step), PH-1) + PH) % PH;
            endcase
        end
    endtask

    function automatic logic [4:0] outs();
        return {mask_bit, mask_valid, frame_start, line_end, frame_end};
    endfunction

    // One clock: check what is presented now, update the model for the coming edge, then step.
    task automatic cyc(input bit rdy, input bit ld, input logic [PN-1:0] pv);
        int x, y;
        logic eb;
        mask_ready = rdy; load_pattern = ld; pattern = pv;
        chk("mask_valid", mask_valid, m_stream);
        if (!m_stream) chk("idle_outputs", outs(), 5'b0);
        if (m_stream && clk_en && rdy) begin
            x = m_k % IW; y = m_k / IW;
            eb = m_pat[((y + m_voff) % PH) * PW + (x + m_hoff) % PW];
            chk("mask_bit", mask_bit, eb);
            chk("frame_start", frame_start, m_k == 0);
            chk("line_end", line_end, x == IW-1);
            chk("frame_end", frame_end, m_k == FR-1);
            if (m_k == 0) begin ones_cnt = 0; fe_at = -1; end
            if (m_k < 8) cap0[m_k] = mask_bit;
            if (m_k >= IW && m_k < IW+8) cap1[m_k-IW] = mask_bit;
            if (mask_bit) ones_cnt++;
            if (frame_end) fe_at = m_k + 1;
            m_k++;
            if (m_k == FR) begin
                m_k = 0; n_frames++; last_ones = ones_cnt;
                model_frame_end();
            end
        end
        if (ld && clk_en) begin
            if (m_stream) begin m_shadow = pv; m_pending = 1; end
            else begin m_pat = pv; m_hoff = 0; m_voff = 0; m_k = 0; m_stream = 1; end
        end
        @(posedge clk); #1;
        load_pattern = 1'b0;
    endtask

    task automatic run_frame(input int ready_pct);
        int start, c;
        start = n_frames; c = 0;
        while (n_frames == start && c < 4*FR + 50) begin
            cyc($urandom_range(0, 99) < ready_pct, 1'b0, pattern);
            c++;
        end
        chk("frame_timeout", n_frames != start, 1);
    endtask

    task automatic advance_to(input int k);
        int c;
        c = 0;
        while (m_k != k && c < 2*FR) begin
            cyc(1'b1, 1'b0, pattern);
            c++;
        end
        chk("advance_timeout", m_k, k);
    endtask

    initial begin
        tv[0] = '{2'b00, 3'd3, 8'b00000111, 8'b11100000};
        tv[1] = '{2'b01, 3'd3, 8'b11100000, 8'b00011100};
        tv[2] = '{2'b01, 3'd3, 8'b00000111, 8'b11100000};
        tv[3] = '{2'b10, 3'd1, 8'b00111000, 8'b00000111};
        tv[4] = '{2'b11, 3'd7, 8'b00000111, 8'b00111000};
        tv[5] = '{2'b00, 3'd7, 8'b00111000, 8'b00000111};
        tv[6] = '{2'b00, 3'd0, 8'b01110000, 8'b00001110};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 5'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_reset", outs(), 5'b0);

        cyc(1'b1, 1'b1, TEST_PAT);
        chk("valid_after_load", mask_valid, 1);
        chk("first_bit_after_load", {mask_bit, frame_start}, 2'b11);

        for (int i = 0; i < 7; i++) begin
            dir = tv[i].dir; step = tv[i].step;
            run_frame(75);
            chk("line0_bits", cap0, tv[i].exp0);
            chk("line1_bits", cap1, tv[i].exp1);
            chk("frame_end_at", fe_at, FR);
        end

        // Stall mid-line, then stall on the line_end pixel itself.
        dir = 2'b01; step = 3'd3;
        for (int t = 0; t < 2; t++) begin
            advance_to(2*IW - 3 + 2*t);
            snap = outs();
            for (int j = 0; j < 5; j++) begin
                cyc(1'b0, 1'b0, pattern);
                chk("stall_hold", outs(), snap);
            end
        end
        run_frame(100);

        advance_to(100);
        cyc(1'b1, 1'b1, '1);
        run_frame(100);
        advance_to(50);
        cyc(1'b1, 1'b1, TEST_PAT);
        run_frame(100);
        chk("all_ones_frame", last_ones, FR);
        run_frame(100);
        chk("reload_offsets_zero", cap0, 8'b00000111);

        for (int f = 0; f < 3; f++) begin
            dir = 2'($urandom); step = SW'($urandom);
            advance_to($urandom_range(1, FR-2));
            cyc(1'b1, 1'b1, PN'($urandom));
            run_frame(50);
        end

        advance_to(300);
        snap = outs();
        clk_en = 1'b0;
        for (int j = 0; j < 4; j++) begin
            cyc(1'b1, j == 1, '1);
            chk("clk_en_hold", outs(), snap);
        end
        clk_en = 1'b1;
        run_frame(100);
        run_frame(100);

        advance_to(500);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outputs", outs(), 5'b0);
        m_stream = 0; m_pending = 0; m_pat = '0; m_hoff = 0; m_voff = 0; m_k = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        for (int j = 0; j < 3; j++) cyc(1'b1, 1'b0, pattern);
        clk_en = 1'b0;
        cyc(1'b1, 1'b1, TEST_PAT);
        clk_en = 1'b1;
        cyc(1'b1, 1'b0, pattern);
        cyc(1'b1, 1'b1, TEST_PAT);
        dir = 2'b00; step = 3'd3;
        run_frame(100);
        chk("post_reset_line0", cap0, 8'b00000111);
        chk("post_reset_line1", cap1, 8'b11100000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
